// File: rtl/alu_multiciclo.sv
// Multicycle ALU: single-cycle logic/add/sub/slt, iterative shift-add mult and restoring div.
// Optional macro ALU_FAST_MULT_EN makes mult combinational with 1-cycle latency.
module alu_multiciclo #(
  parameter int WIDTH = 32
) (
  input  logic             Clock_i,
  input  logic             Reset_i,
  input  logic             Start_i,
  input  logic [5:0]       ALU_Ctrl_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  output logic [WIDTH-1:0] Result_o,
  output logic [WIDTH-1:0] Hi_o,
  output logic             Zero_o,
  output logic             Div_Zero_o,
  output logic             Busy_o,
  output logic             Done_o
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_MULT = 6'b000010;
  localparam logic [5:0] OP_DIV  = 6'b000011;
  localparam logic [5:0] OP_OR   = 6'b000100;
  localparam logic [5:0] OP_AND  = 6'b000101;
  localparam logic [5:0] OP_NOT  = 6'b000110;
  localparam logic [5:0] OP_SLT  = 6'b000111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               zero_q, zero_d;
  logic               divz_q, divz_d;

  logic [WIDTH-1:0]   single_res;
  logic [WIDTH-1:0]   single_hi;
  logic               iterative;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_step;
  logic [2*WIDTH-1:0] iter_step;

  always_comb begin
    single_res = '0;
    single_hi  = '0;
    case (ALU_Ctrl_i)
      OP_ADD:  single_res = A_i + B_i;
      OP_SUB:  single_res = A_i - B_i;
      OP_OR:   single_res = A_i | B_i;
      OP_AND:  single_res = A_i & B_i;
      OP_NOT:  single_res = ~A_i;
      OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(A_i) < $signed(B_i))};
`ifdef ALU_FAST_MULT_EN
      OP_MULT: {single_hi, single_res} = A_i * B_i;
`endif
      default: single_res = '0;
    endcase
  end

`ifdef ALU_FAST_MULT_EN
  assign iterative = (ALU_Ctrl_i == OP_DIV);
`else
  assign iterative = (ALU_Ctrl_i == OP_MULT) || (ALU_Ctrl_i == OP_DIV);
`endif

  // acc holds {hi, multiplier} for mult and {remainder, quotient} for div.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_step  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, b_q};
    if (!div_trial[WIDTH]) begin
      div_step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
    iter_step = is_div_q ? div_step : mul_step;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    divz_d   = divz_q;
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) state_d = IDLE;
        if (Start_i) begin
          divz_d = 1'b0;
          if (iterative) begin
            state_d  = RUN;
            cnt_d    = CW'(WIDTH);
            a_d      = A_i;
            b_d      = B_i;
            is_div_d = (ALU_Ctrl_i == OP_DIV);
            acc_d    = (ALU_Ctrl_i == OP_DIV) ? {{WIDTH{1'b0}}, A_i} : {{WIDTH{1'b0}}, B_i};
          end else begin
            state_d  = DONE;
            result_d = single_res;
            hi_d     = single_hi;
            zero_d   = (single_res == '0);
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        acc_d = iter_step;
        // Division by zero falls out of the restoring loop as all-ones / A.
        if (cnt_q == CW'(1)) begin
          state_d  = DONE;
          result_d = iter_step[WIDTH-1:0];
          hi_d     = iter_step[2*WIDTH-1:WIDTH];
          zero_d   = (iter_step[WIDTH-1:0] == '0);
          divz_d   = is_div_q && (b_q == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b1;
      divz_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      divz_q   <= divz_d;
    end
  end

  assign Result_o   = result_q;
  assign Hi_o       = hi_q;
  assign Zero_o     = zero_q;
  assign Div_Zero_o = divz_q;
  assign Busy_o     = (state_q == RUN);
  assign Done_o     = (state_q == DONE);

endmodule
